// File: rtl/pdm_mic_rx.sv
// pdm_mic_rx: PDM microphone receiver. Generates the PDM bit clock, samples the
// 1-bit stream and decimates it to signed PCM with a CIC filter. PCM samples
// leave through a valid/ready holding register with a sticky overrun flag.
// Optional build macro PDM_RAW_CAPTURE_EN adds raw_byte/raw_valid, which expose
// the sampled bits packed MSB-first into bytes.
module pdm_mic_rx #(
    parameter int unsigned CLK_DIV   = 50,
    parameter int unsigned CIC_ORDER = 4,
    parameter int unsigned DECIM     = 64,
    parameter int unsigned OUT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_din,
    output logic             pdm_clk,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
`ifdef PDM_RAW_CAPTURE_EN
    ,
    output logic [7:0]       raw_byte,
    output logic             raw_valid
`endif
);

    localparam int unsigned DEC_W  = $clog2(DECIM);
    localparam int unsigned ACC_W  = CIC_ORDER * DEC_W + 2;
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned HALF   = CLK_DIV / 2;
    localparam int unsigned WARM_W = $clog2(CIC_ORDER + 1);

    // Divider state; run_q keeps the counter at 0 on the first edge after reset
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             run_q, run_d;
    logic             pdm_clk_q, pdm_clk_d;
    logic             strobe_c;

    // CIC datapath
    logic [CIC_ORDER-1:0][ACC_W-1:0] integ_q, integ_d;
    logic [CIC_ORDER-1:0][ACC_W-1:0] comb_dly_q, comb_dly_d;
    logic [OUT_W-1:0]                comb_out_q, comb_out_d;
    logic [ACC_W-1:0]                int_acc_c, cmb_acc_c;

    // Decimation and warm-up control
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic              comb_en_q, comb_en_d;
    logic              comb_vld_q, comb_vld_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;

    // Output holding register
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    // Sample strobe at the last low-phase clock of each PDM bit
    assign strobe_c = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    // Next-state logic for divider, CIC, decimation and output handshake
    always_comb begin
        run_d       = 1'b1;
        div_cnt_d   = div_cnt_q;
        pdm_clk_d   = pdm_clk_q;
        integ_d     = integ_q;
        comb_dly_d  = comb_dly_q;
        comb_out_d  = comb_out_q;
        dec_cnt_d   = dec_cnt_q;
        comb_en_d   = 1'b0;
        comb_vld_d  = 1'b0;
        warm_cnt_d  = warm_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        int_acc_c   = '0;
        cmb_acc_c   = '0;

        if (!run_q || strobe_c) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        pdm_clk_d = (div_cnt_d < DIV_W'(HALF));

        // Integrator cascade; modular wrap is intentional
        if (strobe_c) begin
            int_acc_c = pdm_din ? ACC_W'(1) : {ACC_W{1'b1}};
            for (int i = 0; i < int'(CIC_ORDER); i++) begin
                int_acc_c  = integ_q[i] + int_acc_c;
                integ_d[i] = int_acc_c;
            end
            dec_cnt_d = dec_cnt_q + DEC_W'(1);
            comb_en_d = (dec_cnt_q == DEC_W'(DECIM - 1));
        end

        // Comb cascade on the already-updated last integrator
        if (comb_en_q) begin
            cmb_acc_c = integ_q[CIC_ORDER-1];
            for (int i = 0; i < int'(CIC_ORDER); i++) begin
                comb_dly_d[i] = cmb_acc_c;
                cmb_acc_c     = cmb_acc_c - comb_dly_q[i];
            end
            comb_out_d = cmb_acc_c[ACC_W-1 -: OUT_W];
            if (warm_cnt_q == WARM_W'(CIC_ORDER)) begin
                comb_vld_d = 1'b1;
            end else begin
                warm_cnt_d = warm_cnt_q + WARM_W'(1);
            end
        end

        // Holding register: newest sample wins, overwrite of unconsumed data is sticky
        if (comb_vld_q) begin
            out_data_d  = comb_out_q;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q       <= 1'b0;
            div_cnt_q   <= '0;
            pdm_clk_q   <= 1'b0;
            integ_q     <= '0;
            comb_dly_q  <= '0;
            comb_out_q  <= '0;
            dec_cnt_q   <= '0;
            comb_en_q   <= 1'b0;
            comb_vld_q  <= 1'b0;
            warm_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            run_q       <= run_d;
            div_cnt_q   <= div_cnt_d;
            pdm_clk_q   <= pdm_clk_d;
            integ_q     <= integ_d;
            comb_dly_q  <= comb_dly_d;
            comb_out_q  <= comb_out_d;
            dec_cnt_q   <= dec_cnt_d;
            comb_en_q   <= comb_en_d;
            comb_vld_q  <= comb_vld_d;
            warm_cnt_q  <= warm_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pdm_clk   = pdm_clk_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef PDM_RAW_CAPTURE_EN
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] raw_byte_q, raw_byte_d;
    logic       raw_valid_q, raw_valid_d;

    // Pack sampled bits MSB-first; publish one edge after the 8th strobe
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        raw_byte_d  = raw_byte_q;
        raw_valid_d = byte_done_q;
        if (strobe_c) begin
            shift_d     = {shift_q[6:0], pdm_din};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
        end
        if (byte_done_q) begin
            raw_byte_d = shift_q;
        end
    end

    // Raw capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            raw_byte_q  <= '0;
            raw_valid_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            raw_byte_q  <= raw_byte_d;
            raw_valid_q <= raw_valid_d;
        end
    end

    assign raw_byte  = raw_byte_q;
    assign raw_valid = raw_valid_q;
`endif

endmodule

// File: doc/pdm_mic_rx.md
Name: pdm_mic_rx

Overview:
- Receiver end of the PDM microphone interface. Generates the PDM bit clock, samples the 1-bit PDM stream, and decimates it to signed PCM with a CIC filter.
- PCM samples leave through a valid/ready holding register.
- Sits behind a real mic or the wavetable PDM generator in the mic-array filter chain. Feeds the downstream FIR/beamforming stages.

Parameters:
- CLK_DIV, 50: system clocks per PDM bit (even, ≥4). At 100 MHz this gives a 2 MHz pdm_clk.
- CIC_ORDER, 4: number of integrator/comb stages (1..5).
- DECIM, 64: decimation ratio (power of two, 8..256).
- OUT_W, 16: PCM output width (≤ ACC_W).
- ACC_W, derived localparam: CIC_ORDER*log2(DECIM)+2. Default is 26.

Ports:
- clk, in, 1: system clock (100 MHz nominal).
- reset, in, 1: synchronous, active-high.
- pdm_din, in, 1: PDM data from mic or wave generator.
- pdm_clk, out, 1: PDM bit clock driven to the mic.
- out_data, out, OUT_W: signed PCM sample (two's complement).
- out_valid, out, 1: out_data holds an unconsumed sample.
- out_ready, in, 1: consumer accepts the sample when out_valid && out_ready at a clk edge.
- overrun, out, 1: sticky; set when an unconsumed sample was overwritten.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - Divider counter, integrators, combs, decimation counter and warm-up counter are cleared.
  - pdm_clk=0, out_data=0, out_valid=0, overrun=0.
  - Reset asserted mid-frame behaves identically: partial frames are discarded and warm-up restarts.
- Clock divider: counter div_cnt runs 0..CLK_DIV-1 and wraps.
  - pdm_clk is registered and high while div_cnt < CLK_DIV/2, low otherwise.
  - First clk edge after reset release gives div_cnt=0 and pdm_clk=1.
- Sampling: a one-cycle sample strobe fires when div_cnt==CLK_DIV-1, at the end of the low phase.
  - pdm_din is captured on that edge and mapped 1→+1, 0→−1.
- Integrators: CIC_ORDER cascaded ACC_W-bit accumulators, updated only on the sample strobe.
  - Wrap-around is modular, with no saturation. This is required for CIC correctness.
- Decimation: dec_cnt counts strobes 0..DECIM-1.
  - On the strobe where dec_cnt==DECIM-1, comb_en is registered high for exactly one cycle.
- Combs: CIC_ORDER differential stages (delay 1) evaluated on comb_en using the updated last-integrator value.
  - The comb output register loads on comb_en.
  - The result is out_data = comb_out[ACC_W-1 -: OUT_W] (truncation, no rounding). It loads into the holding register on the following edge.
  - Total latency: the holding register loads on the 2nd clk edge after the sampling edge of the DECIM-th bit.
- Warm-up: the first CIC_ORDER comb results after reset are discarded and do not touch out_valid, out_data or overrun.
  - The first valid sample therefore follows (CIC_ORDER+1)*DECIM PDM bits.
- Output handshake:
  - New sample with out_valid=0: load out_data, out_valid←1.
  - out_valid && out_ready with no new sample: out_valid←0 on that edge; out_data holds its value.
  - New sample arriving on the same edge as out_valid && out_ready: old sample is consumed, new one loaded, out_valid stays 1, no overrun.
  - New sample while out_valid && !out_ready: out_data is overwritten with the newest sample, out_valid stays 1, overrun←1.
  - overrun clears only on reset.
- Full-scale values at defaults: constant 1s gives +2^24 in the accumulator, so out_data=0x4000. Constant 0s gives 0xC000. Alternating 1/0 gives 0x0000.

Optional Feature:
- Macro: PDM_RAW_CAPTURE_EN.
- When defined, adds ports raw_byte (out, 8) and raw_valid (out, 1).
  - Sampled PDM bits are packed big-endian: the first bit goes to bit 7, the eighth to bit 0. This is the same word format the PDM wavetables use.
  - raw_byte updates and raw_valid pulses high for one clk on the edge after the 8th sample strobe.
  - The bit counter clears on reset. raw_byte resets to 0x00 and raw_valid to 0.
- When undefined, these ports and the packing logic do not exist. CIC behaviour is identical in both builds.

Test Plan:
- Reset held 4 clk, then released → pdm_clk=0, out_valid=0, overrun=0 during reset. Afterwards pdm_clk has a 50-clk period with 25 high / 25 low, starting high on the first edge.
- pdm_din=1 constant, out_ready=1 → no out_valid before 320 PDM bits. Each sample then reads out_data=0x4000 as a one-cycle valid pulse every 3200 clk.
- pdm_din=0 constant → 0xC000. pdm_din alternating 1,0 → 0x0000 after warm-up.
- out_ready=0 across two sample periods with constant 1s then switched to 0s → out_valid stays 1, out_data shows the latest sample, overrun=1. Raising out_ready drops out_valid the next edge, and overrun stays 1.
- Reset pulsed mid-frame at bit 100 of a steady stream → all outputs return to reset values, and the next out_valid appears only after another 320 bits.
- With PDM_RAW_CAPTURE_EN, drive bits 1,0,1,0,0,1,0,1 → raw_byte=0xA5 with a single-cycle raw_valid. A following 0xFF pattern → raw_byte=0xFF.
